// File: rtl/ks0108_pkg.sv
// Shared constants, opcode encodings and the instruction decoder for the
// KS0108-style panel responder model.
package ks0108_pkg;

  localparam int PAGES  = 8;
  localparam int COLS   = 64;
  localparam int PAGE_W = $clog2(PAGES);
  localparam int COL_W  = $clog2(COLS);
  localparam int ADDR_W = PAGE_W + COL_W;
  localparam int LINE_W = 6;

  // Opcode masks/values. Display on/off is 0011_111d, so bit 0 is the operand.
  localparam logic [7:0] DISP_ONOFF_MASK = 8'b1111_1110;
  localparam logic [7:0] DISP_ONOFF_VAL  = 8'b0011_1110;
  localparam logic [1:0] SET_Y           = 2'b01;
  localparam logic [4:0] SET_PAGE        = 5'b10111;
  localparam logic [1:0] START_LINE      = 2'b11;

  typedef enum logic [2:0] {
    OP_DISP,
    OP_SET_Y,
    OP_SET_PAGE,
    OP_START_LINE,
    OP_BAD
  } op_e;

  // Classify an instruction byte; the encodings are mutually exclusive.
  function automatic op_e decode_op(input logic [7:0] code);
    op_e op;
    op = OP_BAD;
    if ((code & DISP_ONOFF_MASK) == DISP_ONOFF_VAL) op = OP_DISP;
    else if (code[7:6] == SET_Y)                    op = OP_SET_Y;
    else if (code[7:3] == SET_PAGE)                 op = OP_SET_PAGE;
    else if (code[7:6] == START_LINE)               op = OP_START_LINE;
    return op;
  endfunction

endpackage

// File: rtl/ks0108_ram.sv
// 512x8 display RAM: one synchronous write port, one registered read port
// with read-before-write behaviour on same-address collisions.
module ks0108_ram
  import ks0108_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [PAGE_W-1:0] wr_page,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [7:0]        wr_data,
  input  logic [PAGE_W-1:0] rd_page,
  input  logic [COL_W-1:0]  rd_col,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [PAGES*COLS];
  logic [7:0] rd_data_d;
  logic [7:0] rd_data_q;

  // Combinational lookup of the pre-edge contents (gives read-before-write).
  always_comb begin
    rd_data_d = mem[{rd_page, rd_col}];
  end

  // Write port.
  // NOTE: the memory array has no reset so it maps onto block RAM; only the
  // output register below is reset.
  always_ff @(posedge clk) begin
    if (we) mem[{wr_page, wr_col}] <= wr_data;
  end

  // Registered read data, cleared by the system reset only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ks0108_panel_model.sv
// Responder model of one KS0108 controller half: latches bus transfers on the
// lcd_en falling edge, updates its registers and display RAM, and reports
// accepted writes, commands and protocol errors.
module ks0108_panel_model
  import ks0108_pkg::*;
#(
  parameter logic [1:0] CS_MATCH = 2'b10,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lcd_di,
  input  logic              lcd_rw,
  input  logic              lcd_en,
  input  logic              lcd_rst,
  input  logic [1:0]        lcd_cs,
  input  logic [7:0]        lcd_data,
  input  logic [PAGE_W-1:0] rd_page,
  input  logic [COL_W-1:0]  rd_col,
  output logic [7:0]        rd_data,
  output logic              display_on,
  output logic [PAGE_W-1:0] page,
  output logic [COL_W-1:0]  col,
  output logic [LINE_W-1:0] start_line,
  output logic              wr_strobe,
  output logic              cmd_strobe,
  output logic              err,
  output logic [CNT_W-1:0]  write_count
);

  logic              en_q, en_d;
  logic              display_on_q, display_on_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] start_line_q, start_line_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic              cmd_strobe_q, cmd_strobe_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  write_count_q, write_count_d;
  logic              ram_we;
  logic              xfer;

  // Transfer decode and next-state computation.
  // NOTE: every output of this block gets a default first so no latches are
  // inferred when a branch leaves it untouched.
  always_comb begin
    en_d          = lcd_en;
    display_on_d  = display_on_q;
    page_d        = page_q;
    col_d         = col_q;
    start_line_d  = start_line_q;
    write_count_d = write_count_q;
    wr_strobe_d   = 1'b0;
    cmd_strobe_d  = 1'b0;
    err_d         = 1'b0;
    ram_we        = 1'b0;
    xfer          = en_q && !lcd_en && (lcd_cs == CS_MATCH);

    if (!lcd_rst) begin
      en_d          = 1'b0;
      display_on_d  = 1'b0;
      page_d        = '0;
      col_d         = '0;
      start_line_d  = '0;
      write_count_d = '0;
    end else if (xfer) begin
      if (lcd_rw) begin
        err_d = 1'b1;
      end else if (!lcd_di) begin
        cmd_strobe_d = 1'b1;
        unique case (decode_op(lcd_data))
          OP_DISP:       display_on_d = lcd_data[0];
          OP_SET_Y:      col_d        = lcd_data[COL_W-1:0];
          OP_SET_PAGE:   page_d       = lcd_data[PAGE_W-1:0];
          OP_START_LINE: start_line_d = lcd_data[LINE_W-1:0];
          default: begin
            cmd_strobe_d = 1'b0;
            err_d        = 1'b1;
          end
        endcase
      end else begin
        ram_we        = 1'b1;
        col_d         = col_q + COL_W'(1);
        wr_strobe_d   = 1'b1;
        write_count_d = write_count_q + CNT_W'(1);
      end
    end
  end

  // State and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q          <= 1'b0;
      display_on_q  <= 1'b0;
      page_q        <= '0;
      col_q         <= '0;
      start_line_q  <= '0;
      wr_strobe_q   <= 1'b0;
      cmd_strobe_q  <= 1'b0;
      err_q         <= 1'b0;
      write_count_q <= '0;
    end else begin
      en_q          <= en_d;
      display_on_q  <= display_on_d;
      page_q        <= page_d;
      col_q         <= col_d;
      start_line_q  <= start_line_d;
      wr_strobe_q   <= wr_strobe_d;
      cmd_strobe_q  <= cmd_strobe_d;
      err_q         <= err_d;
      write_count_q <= write_count_d;
    end
  end

  ks0108_ram u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (ram_we),
    .wr_page (page_q),
    .wr_col  (col_q),
    .wr_data (lcd_data),
    .rd_page (rd_page),
    .rd_col  (rd_col),
    .rd_data (rd_data)
  );

  assign display_on  = display_on_q;
  assign page        = page_q;
  assign col         = col_q;
  assign start_line  = start_line_q;
  assign wr_strobe   = wr_strobe_q;
  assign cmd_strobe  = cmd_strobe_q;
  assign err         = err_q;
  assign write_count = write_count_q;

endmodule
